// File: rtl/alu_z_stage.sv
// Operand/result stage around the combinational ALU: holds operands for a
// settle window, then captures the ALU result into the Zlo/Zhi pair.
module alu_z_stage #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          MASK_SHAMT    = 1'b1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  op_in,
  input  logic        shift_op,
  input  logic        wide_op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [31:0] alu_rz_lo,
  input  logic [31:0] alu_rz_hi,
  output logic [31:0] zlo_out,
  output logic [31:0] zhi_out,
  output logic        busy,
  output logic        done
);

  // state | meaning
  // IDLE  | waiting for start, operands and Z hold
  // EXEC  | operands driven to the ALU, settle counter running
  // DONE  | Z just captured; a new start is accepted here
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       wide_q;
  logic       accept;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end else begin
          state_nxt = IDLE;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wide_q  <= 1'b0;
      alu_a   <= 32'h0;
      alu_b   <= 32'h0;
      alu_op  <= 5'h0;
      zlo_out <= 32'h0;
      zhi_out <= 32'h0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_a  <= a_in;
        alu_op <= op_in;
        // masking the count to 5 bits turns any rotate into a mod-32 rotate
        alu_b  <= (MASK_SHAMT && shift_op) ? {27'b0, b_in[4:0]} : b_in;
        wide_q <= wide_op;
        cnt    <= CNT_INIT;
      end else if (state == EXEC) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          zlo_out <= alu_rz_lo;
          zhi_out <= wide_q ? alu_rz_hi : 32'h0;
        end
      end
    end
  end

  assign busy = (state == EXEC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_alu_z_stage.sv
// Bench for alu_z_stage: two instances (count masking on and off) sharing
// stimulus, each with its own behavioural ALU stub.
module tb_alu_z_stage;

  localparam int S = 2;
  localparam logic [4:0] OP_ROR = 5'd0, OP_ROL = 5'd1, OP_SHL = 5'd2,
                         OP_SHR = 5'd3, OP_ADD = 5'd4, OP_MUL = 5'd5,
                         OP_DIV = 5'd6, OP_STUB = 5'd7;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  op_in = 5'd0;
  logic        shift_op = 1'b0;
  logic        wide_op = 1'b0;
  logic [31:0] a_in = 32'h0;
  logic [31:0] b_in = 32'h0;
  logic [31:0] stub_lo = 32'h0;
  logic [31:0] stub_hi = 32'h0;

  logic [31:0] a1, b1, rzlo1, rzhi1, zlo1, zhi1;
  logic [4:0]  o1;
  logic        busy1, done1;
  logic [31:0] a0, b0, rzlo0, rzhi0, zlo0, zhi0;
  logic [4:0]  o0;
  logic        busy0, done0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  alu_z_stage #(.SETTLE_CYCLES(S), .MASK_SHAMT(1'b1)) u_dut (
    .clock(clock), .clear(clear), .start(start), .op_in(op_in),
    .shift_op(shift_op), .wide_op(wide_op), .a_in(a_in), .b_in(b_in),
    .alu_a(a1), .alu_b(b1), .alu_op(o1), .alu_rz_lo(rzlo1), .alu_rz_hi(rzhi1),
    .zlo_out(zlo1), .zhi_out(zhi1), .busy(busy1), .done(done1));

  alu_z_stage #(.SETTLE_CYCLES(S), .MASK_SHAMT(1'b0)) u_dut0 (
    .clock(clock), .clear(clear), .start(start), .op_in(op_in),
    .shift_op(shift_op), .wide_op(wide_op), .a_in(a_in), .b_in(b_in),
    .alu_a(a0), .alu_b(b0), .alu_op(o0), .alu_rz_lo(rzlo0), .alu_rz_hi(rzhi0),
    .zlo_out(zlo0), .zhi_out(zhi0), .busy(busy0), .done(done0));

  // ALU stand-in; a count of 32 or more leaves a rotate operand unchanged
  function automatic logic [63:0] alu_stub(logic [4:0] op, logic [31:0] a, logic [31:0] b,
                                           logic [31:0] slo, logic [31:0] shi);
    logic [31:0] lo, hi;
    logic [63:0] p;
    lo = a ^ b;
    hi = 32'h0;
    p  = 64'h0;
    case (op)
      OP_ROR:  lo = (b >= 32'd32) ? a : ((a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]})));
      OP_ROL:  lo = (b >= 32'd32) ? a : ((a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]})));
      OP_SHL:  lo = a << b;
      OP_SHR:  lo = a >> b;
      OP_ADD:  lo = a + b;
      OP_MUL:  begin p = {32'h0, a} * {32'h0, b}; lo = p[31:0]; hi = p[63:32]; end
      OP_DIV:  begin
        if (b == 32'h0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      OP_STUB: begin lo = slo; hi = shi; end
      default: lo = a ^ b;
    endcase
    if (op != OP_MUL && op != OP_DIV && op != OP_STUB) hi = ~lo;
    return {hi, lo};
  endfunction

  always_comb {rzhi1, rzlo1} = alu_stub(o1, a1, b1, stub_lo, stub_hi);
  always_comb {rzhi0, rzlo0} = alu_stub(o0, a0, b0, stub_lo, stub_hi);

  // Reference: what Z and the ALU count should be after one operation
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic sh, input logic wd, input bit mask,
                       output logic [31:0] xb, output logic [31:0] xlo, output logic [31:0] xhi);
    logic [31:0] lo, hi;
    logic [63:0] p;
    longint unsigned n;
    xb = (mask && sh) ? (b % 32) : b;
    n  = longint'(xb);
    lo = a ^ xb;
    hi = 32'h0;
    case (op)
      OP_ROR: begin lo = a; if (n < 32) for (int i = 0; i < n; i++) lo = {lo[0], lo[31:1]}; end
      OP_ROL: begin lo = a; if (n < 32) for (int i = 0; i < n; i++) lo = {lo[30:0], lo[31]}; end
      OP_SHL: begin p = 64'(a) * (64'd1 << n); lo = (n >= 32) ? 32'h0 : p[31:0]; end
      OP_SHR: lo = (n >= 32) ? 32'h0 : 32'(64'(a) / (64'd1 << n));
      OP_ADD: begin p = 64'(a) + 64'(xb); lo = p[31:0]; end
      OP_MUL: begin p = 64'(a) * 64'(xb); lo = p[31:0]; hi = p[63:32]; end
      OP_DIV: begin
        if (xb == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / xb; hi = a % xb; end
      end
      OP_STUB: begin lo = stub_lo; hi = stub_hi; end
      default: lo = a ^ xb;
    endcase
    if (op != OP_MUL && op != OP_DIV && op != OP_STUB) hi = ~lo;
    xlo = lo;
    xhi = wd ? hi : 32'h0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " a1"}, 64'(a1), 64'h0);   chk({tag, " b1"}, 64'(b1), 64'h0);
    chk({tag, " op1"}, 64'(o1), 64'h0);  chk({tag, " zlo1"}, 64'(zlo1), 64'h0);
    chk({tag, " zhi1"}, 64'(zhi1), 64'h0); chk({tag, " busy1"}, 64'(busy1), 64'h0);
    chk({tag, " done1"}, 64'(done1), 64'h0);
    chk({tag, " zlo0"}, 64'(zlo0), 64'h0); chk({tag, " busy0"}, 64'(busy0), 64'h0);
    chk({tag, " done0"}, 64'(done0), 64'h0);
  endtask

  // One operation; noise=1 wiggles start and the operand inputs during EXEC
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic sh, input logic wd, input bit noise);
    logic [31:0] xb1, xlo1, xhi1, xb0, xlo0, xhi0;
    model(op, a, b, sh, wd, 1'b1, xb1, xlo1, xhi1);
    model(op, a, b, sh, wd, 1'b0, xb0, xlo0, xhi0);
    @(negedge clock);
    start = 1'b1; op_in = op; a_in = a; b_in = b; shift_op = sh; wide_op = wd;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < S; k++) begin
      chk("exec busy", 64'({busy1, busy0}), 64'b11);
      chk("exec done", 64'({done1, done0}), 64'b00);
      chk("alu_a", 64'({a1, a0}), {a, a});
      chk("alu_op", 64'({o1, o0}), 64'({op, op}));
      chk("alu_b", 64'({b1, b0}), {xb1, xb0});
      if (noise) begin
        start = 1'($urandom_range(0, 1)); a_in = $urandom; b_in = $urandom;
        op_in = 5'($urandom_range(0, 31)); shift_op = 1'($urandom_range(0, 1));
        wide_op = 1'($urandom_range(0, 1));
      end
      @(negedge clock);
    end
    start = 1'b0;
    chk("done pulse", 64'({done1, done0, busy1, busy0}), 64'b1100);
    chk("zlo1", 64'(zlo1), 64'(xlo1));
    chk("zhi1", 64'(zhi1), 64'(xhi1));
    chk("zlo0", 64'(zlo0), 64'(xlo0));
    chk("zhi0", 64'(zhi0), 64'(xhi0));
    @(negedge clock);
    chk("after done", 64'({done1, done0, busy1, busy0}), 64'b0000);
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        sh, wd;
    logic [31:0] slo, shi;
    logic [31:0] exp_b, exp_lo, exp_hi;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [31:0] keep_lo, keep_a;
    tbl[0] = '{OP_ROR,  32'h0000_0001, 32'd1,  1'b1, 1'b0, 32'h0, 32'h0, 32'd1,  32'h8000_0000, 32'h0};
    tbl[1] = '{OP_ROR,  32'h1234_5678, 32'd33, 1'b1, 1'b0, 32'h0, 32'h0, 32'd1,  32'h091A_2B3C, 32'h0};
    tbl[2] = '{OP_STUB, 32'h0,         32'd5,  1'b0, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 32'd5, 32'h1234_5678, 32'hDEAD_BEEF};
    tbl[3] = '{OP_ADD,  32'hFFFF_FFFF, 32'd2,  1'b0, 1'b0, 32'h0, 32'h0, 32'd2,  32'h0000_0001, 32'h0};
    tbl[4] = '{OP_ROL,  32'h8000_0001, 32'd36, 1'b1, 1'b0, 32'h0, 32'h0, 32'd4,  32'h0000_0018, 32'h0};
    tbl[5] = '{OP_SHL,  32'h0000_0001, 32'd31, 1'b1, 1'b0, 32'h0, 32'h0, 32'd31, 32'h8000_0000, 32'h0};
    tbl[6] = '{OP_MUL,  32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0001_0000, 32'h0, 32'h1};
    tbl[7] = '{OP_STUB, 32'h0,         32'd0,  1'b0, 1'b0, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'd0, 32'hCAFE_F00D, 32'h0};

    repeat (2) @(negedge clock);
    chk_zero("reset");
    clear = 1'b0;

    for (int i = 0; i < 8; i++) begin
      stub_lo = tbl[i].slo; stub_hi = tbl[i].shi;
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, tbl[i].wd, (i % 2) == 1);
      chk("tbl alu_b", 64'(b1), 64'(tbl[i].exp_b));
      chk("tbl zlo", 64'(zlo1), 64'(tbl[i].exp_lo));
      chk("tbl zhi", 64'(zhi1), 64'(tbl[i].exp_hi));
    end

    // count >= 32 passes through unmasked on the second instance
    run_op(OP_ROR, 32'h1234_5678, 32'd33, 1'b1, 1'b0, 1'b0);
    chk("nomask alu_b", 64'(b0), 64'h21);
    chk("nomask zlo", 64'(zlo0), 64'h1234_5678);
    chk("mask zlo", 64'(zlo1), 64'h091A_2B3C);

    // Z and operands hold while idle
    keep_lo = zlo1; keep_a = a1;
    a_in = 32'h5555_AAAA;
    repeat (3) @(negedge clock);
    chk("hold zlo", 64'(zlo1), 64'(keep_lo));
    chk("hold alu_a", 64'(a1), 64'(keep_a));

    // start held through DONE: second op accepted without an idle cycle
    @(negedge clock);
    start = 1'b1; op_in = OP_ADD; a_in = 32'd10; b_in = 32'd20; shift_op = 1'b0; wide_op = 1'b0;
    @(negedge clock);
    op_in = OP_ROR; a_in = 32'h0000_0003; b_in = 32'd1; shift_op = 1'b1;
    chk("b2b busy a", 64'({busy1, done1}), 64'b10);
    chk("b2b alu_a a", 64'(a1), 64'd10);
    @(negedge clock);
    chk("b2b busy b", 64'({busy1, done1}), 64'b10);
    @(negedge clock);
    chk("b2b done1", 64'({busy1, done1}), 64'b01);
    chk("b2b zlo1", 64'(zlo1), 64'd30);
    @(negedge clock);
    start = 1'b0;
    chk("b2b busy c", 64'({busy1, done1}), 64'b10);
    chk("b2b alu_a c", 64'(a1), 64'h3);
    chk("b2b alu_b c", 64'(b1), 64'h1);
    @(negedge clock);
    chk("b2b busy d", 64'({busy1, done1}), 64'b10);
    @(negedge clock);
    chk("b2b done2", 64'({busy1, done1}), 64'b01);
    chk("b2b zlo2", 64'(zlo1), 64'h8000_0001);
    @(negedge clock);
    chk("b2b idle", 64'({busy1, done1}), 64'b00);

    // clear with start high in the second EXEC cycle aborts the operation
    @(negedge clock);
    start = 1'b1; op_in = OP_ADD; a_in = 32'd5; b_in = 32'd6; shift_op = 1'b0;
    @(negedge clock);
    start = 1'b0;
    chk("abort busy", 64'(busy1), 64'h1);
    @(negedge clock);
    clear = 1'b1; start = 1'b1; a_in = 32'h7777_0000;
    @(negedge clock);
    chk_zero("abort");
    clear = 1'b0; start = 1'b0;
    @(negedge clock);
    chk("abort no done", 64'({done1, busy1}), 64'b00);
    chk("abort no capture", 64'(zlo1), 64'h0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] rb;
      rb = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 70)) : $urandom;
      stub_lo = $urandom; stub_hi = $urandom;
      run_op(5'($urandom_range(0, 8)), $urandom, rb, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
